simple_add_example_packet_summer: RTL and testbench
===================================================

Name: simple_add_example_packet_summer

Overview:
- Sits directly downstream of the pipelined adder FIFO output (m_axis side) and consumes its AXI4-Stream.
- Sums every fully-kept C_ADDER_BIT_WIDTH lane of every beat in a packet, delimited by tlast.
- Emits exactly one single-beat summary per input packet: sum, beat count, valid-lane count and a partial-keep flag.
- Feeds the kernel's write/result path.

Parameters:
- C_AXIS_TDATA_WIDTH, 512, width of input and output tdata; must be a multiple of C_ADDER_BIT_WIDTH and >= 160.
- C_ADDER_BIT_WIDTH, 32, lane width, matching the adder.
- C_SUM_WIDTH, 64, accumulator width; sum wraps modulo 2^C_SUM_WIDTH.

Ports:
- s_axis_aclk  in  1  single clock for the whole block
- s_axis_areset  in  1  reset; asynchronous, active-high
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  adder results, lane i at [i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH]
- s_axis_tkeep  in  C_AXIS_TDATA_WIDTH/8  byte keep
- s_axis_tlast  in  1  end of packet
- s_axis_tdest  in  16  destination tag
- m_axis_tvalid  out  1  summary valid
- m_axis_tready  in  1  summary ready
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  summary word
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  always all ones
- m_axis_tlast  out  1  always 1 while m_axis_tvalid
- m_axis_tdest  out  16  tdest of the packet's first beat

Behaviour:
- Clock and reset: one clock, s_axis_aclk. Reset s_axis_areset is asynchronous and active-high; it clears every register immediately.
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tdest=0, m_axis_tlast=0.
  - s_axis_tready=1 (combinational, see below).
  - Internal state: first-beat flag=1; accumulator and counters 0; stage-1 valid 0.
- Global advance: adv = ~m_axis_tvalid | m_axis_tready.
  - s_axis_tready = adv (combinational path from m_axis_tready, accepted by design).
  - Every pipeline register enables on adv; nothing drops while stalled.
- Stage 1 (registered, sub-module), on a handshake:
  - Lane i is valid iff its 4 keep bits are all 1.
  - lane_sum = sum of valid lanes, zero-extended to C_SUM_WIDTH.
  - lane_cnt = number of valid lanes.
  - partial = any lane with keep neither all-0 nor all-1.
  - tlast and tdest are registered alongside.
  - Stage-1 valid is set only on a handshake; otherwise it clears when adv.
- Stage 2 (accumulate), when stage-1 valid and adv:
  - If first-beat flag is set: acc = lane_sum, beats = 1, lanes = lane_cnt, perr = partial, capture tdest.
  - Otherwise: acc += lane_sum, beats += 1, lanes += lane_cnt, perr |= partial.
  - If stage-1 tlast: load the output register with the next values, assert m_axis_tvalid, set first-beat flag to 1.
  - Otherwise: first-beat flag is cleared.
- Output word layout:
  - [C_SUM_WIDTH-1:0] = sum.
  - [95:64] = beat count.
  - [127:96] = valid-lane count.
  - [128] = partial-keep error.
  - All other bits 0.
- Latency: m_axis_tvalid rises on the 2nd rising edge after the tlast handshake, with no stall.
- Throughput: one input beat per cycle sustained. Back-to-back packets, including single-beat packets every cycle, are accepted with no bubbles while m_axis_tready=1.
- m_axis_tvalid clears on handshake unless a new summary loads on the same edge; in that case it stays 1 with the new data.
- Output holds stable while m_axis_tvalid & ~m_axis_tready (AXIS rule).
- Wrap: sum wraps modulo 2^C_SUM_WIDTH. Beat and lane counters wrap modulo 2^32. No saturation.
- Beat with tkeep all zero: counts as a beat and contributes 0.
- Reset mid-packet: the partial packet is discarded with no summary. The first beat after reset deassertion starts a new packet.
- tvalid with tready low: no effect on any state.

Decomposition:
- Package simple_add_example_pkg:
  - LP_NUM_LANES = C_AXIS_TDATA_WIDTH/C_ADDER_BIT_WIDTH.
  - Field offsets: SUM_LSB=0, BEATS_LSB=64, LANES_LSB=96, PERR_BIT=128.
  - Counter width 32.
- Sub-module simple_add_example_lane_reduce: registered keep-masked adder tree plus popcount, with enable (adv) and async reset.

Test Plan:
- 1-beat packet, all lanes=1, tkeep all 1, tdest=5 -> single summary 2 cycles later: sum=16, beats=1, lanes=16, perr=0, tdest=5, tlast=1.
- 3-beat packet, lanes=0xFFFFFFFF, tkeep all 1 -> sum=48*(2^32-1)=0x2F_FFFF_FFD0, beats=3, lanes=48, no wrap into bit 64.
- 2-beat packet, beat 2 tkeep=0x00FF (lanes 0-1 only) and 0x0F0F variant -> lanes=18, perr=0 for 0x00FF; for 0x0007 -> perr=1, lanes=16.
- m_axis_tready held 0 for 10 cycles across 4 back-to-back 1-beat packets -> s_axis_tready drops, nothing lost, 4 summaries in order with correct tdest each.
- Assert s_axis_areset asynchronously mid-packet (between edges) -> outputs 0 immediately. Next packet {1 beat, lanes=2} -> sum=32, beats=1, with no stale accumulation.

Source files
------------

// File: rtl/simple_add_example_pkg.sv
// Shared constants for the packet summer: summary word field offsets,
// counter width and the lane-count helper.
package simple_add_example_pkg;

  localparam int unsigned CNT_W        = 32;
  localparam int unsigned SUM_LSB      = 0;
  localparam int unsigned BEATS_LSB    = 64;
  localparam int unsigned LANES_LSB    = 96;
  localparam int unsigned PERR_BIT     = 128;

  localparam int unsigned DEF_TDATA_W  = 512;
  localparam int unsigned DEF_ADDER_W  = 32;
  localparam int unsigned LP_NUM_LANES = DEF_TDATA_W / DEF_ADDER_W;

  function automatic int unsigned num_lanes(input int unsigned tdata_w,
                                            input int unsigned adder_w);
    return tdata_w / adder_w;
  endfunction

endpackage

// File: rtl/simple_add_example_lane_reduce.sv
// Stage 1: registered keep-masked lane sum, full-lane popcount and
// partial-keep detection for one AXIS beat.
module simple_add_example_lane_reduce
  import simple_add_example_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_ADDER_BIT_WIDTH  = 32,
  parameter int unsigned C_SUM_WIDTH        = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_en,
  input  logic                            i_valid,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   i_data,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] i_keep,
  input  logic                            i_last,
  input  logic [15:0]                     i_dest,
  output logic                            o_valid,
  output logic [C_SUM_WIDTH-1:0]          o_sum,
  output logic [CNT_W-1:0]                o_cnt,
  output logic                            o_partial,
  output logic                            o_last,
  output logic [15:0]                     o_dest
);

  localparam int unsigned LP_LANES = num_lanes(C_AXIS_TDATA_WIDTH, C_ADDER_BIT_WIDTH);
  localparam int unsigned LP_KB    = C_ADDER_BIT_WIDTH / 8;

  logic [C_SUM_WIDTH-1:0] w_sum;
  logic [CNT_W-1:0]       w_cnt;
  logic                   w_partial;
  logic [LP_KB-1:0]       w_keep_lane;

  logic                   r_valid;
  logic [C_SUM_WIDTH-1:0] r_sum;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_partial;
  logic                   r_last;
  logic [15:0]            r_dest;

  always_comb begin
    w_sum       = '0;
    w_cnt       = '0;
    w_partial   = 1'b0;
    w_keep_lane = '0;
    for (int unsigned i = 0; i < LP_LANES; i++) begin
      w_keep_lane = i_keep[i*LP_KB +: LP_KB];
      if (&w_keep_lane) begin
        w_sum = w_sum + C_SUM_WIDTH'(i_data[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH]);
        w_cnt = w_cnt + CNT_W'(1);
      end else if (|w_keep_lane) begin
        w_partial = 1'b1;
      end
    end
  end

  // i_en is the global advance, so i_valid here already implies a handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_partial <= 1'b0;
      r_last    <= 1'b0;
      r_dest    <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_sum     <= w_sum;
        r_cnt     <= w_cnt;
        r_partial <= w_partial;
        r_last    <= i_last;
        r_dest    <= i_dest;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_sum     = r_sum;
  assign o_cnt     = r_cnt;
  assign o_partial = r_partial;
  assign o_last    = r_last;
  assign o_dest    = r_dest;

endmodule

// File: rtl/simple_add_example_packet_summer.sv
// Consumes the adder AXIS output and emits one single-beat summary per
// packet: lane sum, beat count, full-lane count and partial-keep flag.
module simple_add_example_packet_summer
  import simple_add_example_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
  parameter int unsigned C_ADDER_BIT_WIDTH  = 32,
  parameter int unsigned C_SUM_WIDTH        = 64
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  input  logic [15:0]                     s_axis_tdest,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [15:0]                     m_axis_tdest
);

  logic                          w_adv;
  logic                          w_s1_valid;
  logic [C_SUM_WIDTH-1:0]        w_s1_sum;
  logic [CNT_W-1:0]              w_s1_cnt;
  logic                          w_s1_partial;
  logic                          w_s1_last;
  logic [15:0]                   w_s1_dest;

  logic [C_SUM_WIDTH-1:0]        w_acc_n;
  logic [CNT_W-1:0]              w_beats_n;
  logic [CNT_W-1:0]              w_lanes_n;
  logic                          w_perr_n;
  logic [15:0]                   w_dest_n;
  logic [C_AXIS_TDATA_WIDTH-1:0] w_word;

  logic                          r_first;
  logic [C_SUM_WIDTH-1:0]        r_acc;
  logic [CNT_W-1:0]              r_beats;
  logic [CNT_W-1:0]              r_lanes;
  logic                          r_perr;
  logic [15:0]                   r_dest;
  logic                          r_m_valid;
  logic [C_AXIS_TDATA_WIDTH-1:0] r_m_data;
  logic [15:0]                   r_m_dest;

  assign w_adv         = ~r_m_valid | m_axis_tready;
  assign s_axis_tready = w_adv;

  simple_add_example_lane_reduce #(
    .C_AXIS_TDATA_WIDTH (C_AXIS_TDATA_WIDTH),
    .C_ADDER_BIT_WIDTH  (C_ADDER_BIT_WIDTH),
    .C_SUM_WIDTH        (C_SUM_WIDTH)
  ) u_lane_reduce (
    .clk       (s_axis_aclk),
    .rst       (s_axis_areset),
    .i_en      (w_adv),
    .i_valid   (s_axis_tvalid),
    .i_data    (s_axis_tdata),
    .i_keep    (s_axis_tkeep),
    .i_last    (s_axis_tlast),
    .i_dest    (s_axis_tdest),
    .o_valid   (w_s1_valid),
    .o_sum     (w_s1_sum),
    .o_cnt     (w_s1_cnt),
    .o_partial (w_s1_partial),
    .o_last    (w_s1_last),
    .o_dest    (w_s1_dest)
  );

  // Next accumulator values; a first beat restarts rather than adds.
  always_comb begin
    w_acc_n   = r_first ? w_s1_sum     : r_acc + w_s1_sum;
    w_beats_n = r_first ? CNT_W'(1)    : r_beats + CNT_W'(1);
    w_lanes_n = r_first ? w_s1_cnt     : r_lanes + w_s1_cnt;
    w_perr_n  = r_first ? w_s1_partial : r_perr | w_s1_partial;
    w_dest_n  = r_first ? w_s1_dest    : r_dest;
    w_word                        = '0;
    w_word[SUM_LSB +: C_SUM_WIDTH] = w_acc_n;
    w_word[BEATS_LSB +: CNT_W]    = w_beats_n;
    w_word[LANES_LSB +: CNT_W]    = w_lanes_n;
    w_word[PERR_BIT]              = w_perr_n;
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_first   <= 1'b1;
      r_acc     <= '0;
      r_beats   <= '0;
      r_lanes   <= '0;
      r_perr    <= 1'b0;
      r_dest    <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_dest  <= '0;
    end else if (w_adv) begin
      r_m_valid <= w_s1_valid & w_s1_last;
      if (w_s1_valid) begin
        r_acc   <= w_acc_n;
        r_beats <= w_beats_n;
        r_lanes <= w_lanes_n;
        r_perr  <= w_perr_n;
        r_dest  <= w_dest_n;
        r_first <= w_s1_last;
        if (w_s1_last) begin
          r_m_data <= w_word;
          r_m_dest <= w_dest_n;
        end
      end
    end
  end

  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tdest  = r_m_dest;
  assign m_axis_tlast  = r_m_valid;
  assign m_axis_tkeep  = '1;

endmodule

// File: tb/tb_simple_add_example_packet_summer.sv
// Scoreboard bench for the packet summer: packet-level reference model,
// randomized traffic and backpressure, plus directed corner cases.
module tb_simple_add_example_packet_summer;

  localparam int W  = 512;
  localparam int KW = W / 8;
  localparam int NL = W / 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tvalid, s_tready, s_tlast;
  logic [W-1:0]  s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [15:0]   s_tdest;
  logic          m_tvalid, m_tready, m_tlast;
  logic [W-1:0]  m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [15:0]   m_tdest;

  always #5 clk = ~clk;

  simple_add_example_packet_summer #(
    .C_AXIS_TDATA_WIDTH (W),
    .C_ADDER_BIT_WIDTH  (32),
    .C_SUM_WIDTH        (64)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tdest  (s_tdest),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tdest  (m_tdest)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    logic [15:0]   dest;
  } beat_t;

  typedef struct {
    logic [W-1:0] data;
    logic [15:0]  dest;
  } exp_t;

  beat_t pkt_q[$];
  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    rdy_mode = 0;   // 0: ready, 1: random ready, 2: hold not-ready
  logic [KW-1:0] all_keep = '1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] fill(input logic [31:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  // Reference: sum of every fully-kept 32-bit lane over the whole packet.
  function automatic exp_t model();
    exp_t        e;
    logic [63:0] sum;
    logic [31:0] lanes;
    logic [3:0]  k;
    logic        perr;
    sum = '0; lanes = '0; perr = 1'b0;
    foreach (pkt_q[b]) begin
      for (int l = 0; l < NL; l++) begin
        k = pkt_q[b].keep[l*4 +: 4];
        if (k == 4'hF) begin
          sum   = sum + 64'(pkt_q[b].data[l*32 +: 32]);
          lanes = lanes + 32'd1;
        end else if (k != 4'h0) begin
          perr = 1'b1;
        end
      end
    end
    e.data          = '0;
    e.data[63:0]    = sum;
    e.data[95:64]   = 32'(pkt_q.size());
    e.data[127:96]  = lanes;
    e.data[128]     = perr;
    e.dest          = pkt_q[0].dest;
    return e;
  endfunction

  task automatic add_beat(input logic [W-1:0] d, input logic [KW-1:0] k,
                          input logic l, input logic [15:0] t);
    beat_t b;
    b.data = d; b.keep = k; b.last = l; b.dest = t;
    pkt_q.push_back(b);
  endtask

  task automatic send_beat(input beat_t bt);
    int n;
    logic hs;
    s_tvalid = 1'b1; s_tdata = bt.data; s_tkeep = bt.keep;
    s_tlast = bt.last; s_tdest = bt.dest;
    n = 0; hs = 1'b0;
    while (!hs && n < 2000) begin
      @(negedge clk); hs = s_tready;
      @(posedge clk); #1;
      n++;
    end
    s_tvalid = 1'b0;
    if (!hs) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout act=%0d cycles exp=handshake", n);
    end
  endtask

  task automatic send_pkt(input int gap_max);
    sb_q.push_back(model());
    foreach (pkt_q[i]) begin
      send_beat(pkt_q[i]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
    pkt_q.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || m_tvalid) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout act=%0d pending exp=0", sb_q.size());
    end
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 99) < 70);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on each output handshake and checks hold stability under stall.
  initial begin
    exp_t         e;
    logic         held;
    logic [W-1:0] held_data;
    logic [15:0]  held_dest;
    held = 1'b0; held_data = '0; held_dest = '0;
    forever begin
      @(negedge clk);
      if (!rst && m_tvalid) begin
        if (held) begin
          chk("hold_data", m_tdata, held_data);
          chk("hold_dest", W'(m_tdest), W'(held_dest));
        end
        if (m_tready) begin
          held = 1'b0;
          if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_summary act=%0h exp=none", m_tdata);
          end else begin
            e = sb_q.pop_front();
            chk("summary_data", m_tdata, e.data);
            chk("summary_dest", W'(m_tdest), W'(e.dest));
            chk("summary_tlast", W'(m_tlast), W'(1'b1));
            chk("summary_tkeep", W'(m_tkeep), W'(all_keep));
          end
        end else begin
          held = 1'b1; held_data = m_tdata; held_dest = m_tdest;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    longint t0;
    logic [W-1:0] d;
    logic [KW-1:0] k;
    int nb, r;
    beat_t b;

    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tdest = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", W'(m_tvalid), '0);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_m_tdest", W'(m_tdest), '0);
    chk("rst_m_tlast", W'(m_tlast), '0);
    chk("rst_s_tready", W'(s_tready), W'(1'b1));
    rst = 1'b0;
    @(posedge clk); #1;

    // single beat, all lanes 1, latency of two edges
    add_beat(fill(32'd1), '1, 1'b1, 16'd5);
    send_pkt(0);
    chk("lat_not_yet", W'(m_tvalid), '0);
    @(posedge clk); #1;
    chk("lat_valid", W'(m_tvalid), W'(1'b1));
    drain();

    for (int i = 0; i < 3; i++) add_beat(fill(32'hFFFF_FFFF), '1, i == 2, 16'd7);
    send_pkt(0);

    add_beat(fill(32'd3), '1, 1'b0, 16'd9);  add_beat(fill(32'd4), KW'(16'h00FF), 1'b1, 16'd1);
    send_pkt(0);
    add_beat(fill(32'd3), '1, 1'b0, 16'd10); add_beat(fill(32'd4), KW'(16'h0F0F), 1'b1, 16'd2);
    send_pkt(0);
    add_beat(fill(32'd3), '1, 1'b0, 16'd11); add_beat(fill(32'd4), KW'(16'h0007), 1'b1, 16'd3);
    send_pkt(0);
    add_beat(fill(32'd6), '0, 1'b0, 16'd12); add_beat(fill(32'd8), '1, 1'b1, 16'd4);
    send_pkt(0);
    drain();

    // back-to-back single-beat packets, one per cycle
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      add_beat(fill(32'(i + 20)), '1, 1'b1, 16'(i + 40));
      send_pkt(0);
    end
    chk("throughput_time", W'($time - t0), W'(80));
    drain();

    // stall output for 10 cycles across 4 packets
    rdy_mode = 2;
    @(posedge clk); #1;
    fork
      begin
        for (int p = 0; p < 4; p++) begin
          add_beat(fill($urandom), '1, 1'b1, 16'(100 + p));
          send_pkt(0);
        end
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("stall_s_tready", W'(s_tready), '0);
        rdy_mode = 0;
      end
    join
    drain();

    // randomized traffic and backpressure
    rdy_mode = 1;
    for (int p = 0; p < 150; p++) begin
      nb = $urandom_range(1, 4);
      for (int bi = 0; bi < nb; bi++) begin
        d = '0; k = '0;
        for (int l = 0; l < NL; l++) begin
          d[l*32 +: 32] = $urandom;
          r = $urandom_range(0, 7);
          if (r == 5)      k[l*4 +: 4] = 4'h0;
          else if (r == 6) k[l*4 +: 4] = 4'($urandom_range(1, 14));
          else             k[l*4 +: 4] = 4'hF;
        end
        if ($urandom_range(0, 9) == 0) k = '0;
        add_beat(d, k, bi == nb - 1, 16'($urandom));
      end
      send_pkt(2);
    end
    rdy_mode = 0;
    drain();

    // async reset with a held summary and a partial packet in flight
    rdy_mode = 2;
    @(posedge clk); #1;
    b.data = fill(32'd9); b.keep = '1; b.last = 1'b1; b.dest = 16'h0AA;
    send_beat(b);
    b.data = fill(32'd7); b.keep = '1; b.last = 1'b0; b.dest = 16'h0BB;
    send_beat(b);
    #2 rst = 1'b1;
    #1;
    chk("arst_m_tvalid", W'(m_tvalid), '0);
    chk("arst_m_tdata", m_tdata, '0);
    chk("arst_m_tdest", W'(m_tdest), '0);
    chk("arst_m_tlast", W'(m_tlast), '0);
    rdy_mode = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    add_beat(fill(32'd2), '1, 1'b1, 16'd77);
    send_pkt(0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
